// File: rtl/multdiv_ctrl_pkg.sv
// multdiv_ctrl_pkg: state encoding and default timeout for the mult/div sequencer
package multdiv_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;
   localparam int TIMEOUT_DEF = 40;
endpackage

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: pipeline-side request, flush/stall and writeback bundle
interface multdiv_ctrl_if #(parameter int WIDTH = 32, parameter int TAG_W = 5);
   logic             req_valid;
   logic             req_ready;
   logic             req_is_mult;
   logic             req_is_div;
   logic [WIDTH-1:0] req_opA;
   logic [WIDTH-1:0] req_opB;
   logic [TAG_W-1:0] req_dest;
   logic             flush;
   logic             stall;
   logic             wb_valid;
   logic [TAG_W-1:0] wb_dest;
   logic [WIDTH-1:0] wb_data;
   logic             wb_exception;
   modport master (output req_valid, req_is_mult, req_is_div, req_opA, req_opB, req_dest, flush,
                   input req_ready, stall, wb_valid, wb_dest, wb_data, wb_exception);
   modport slave (input req_valid, req_is_mult, req_is_div, req_opA, req_opB, req_dest, flush,
                  output req_ready, stall, wb_valid, wb_dest, wb_data, wb_exception);
endinterface

// File: rtl/multdiv_ctrl_mdu_timeout_counter.sv
// mdu_timeout_counter: 6-bit busy-cycle counter with sync clear and terminal count
module mdu_timeout_counter #(parameter int TC = 40) (
   input  logic clock,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [5:0] cnt;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 6'd1;
   assign tc = cnt == 6'(TC - 1);
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one mult/div op at a time through the shared units to writeback
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   multdiv_ctrl_if.slave     pipe,
   output logic              ctrl_MULT,
   output logic              ctrl_DIV,
   output logic [WIDTH-1:0]  mdu_opA,
   output logic [WIDTH-1:0]  mdu_opB,
   input  logic [WIDTH-1:0]  mult_result,
   input  logic              mult_exception,
   input  logic              mult_rdy,
   input  logic [WIDTH-1:0]  div_result,
   input  logic              div_exception,
   input  logic              div_rdy
);
   state_t           state, state_nx;
   logic             op_mult, op_div, cap_exc, accept, sel_rdy, finish, tc;
   logic [WIDTH-1:0] op_a, op_b, cap_data;
   logic [TAG_W-1:0] dest;
   assign accept  = state == IDLE && pipe.req_valid && (pipe.req_is_mult || pipe.req_is_div) && !pipe.flush;
   assign sel_rdy = op_mult ? mult_rdy : div_rdy;
   assign finish  = state == BUSY && !pipe.flush && (sel_rdy || tc);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? START : IDLE;
         START:   state_nx = pipe.flush ? IDLE : BUSY;
         BUSY:    state_nx = pipe.flush ? IDLE : (sel_rdy || tc) ? DONE : BUSY;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         op_a     <= '0;
         op_b     <= '0;
         dest     <= '0;
         op_mult  <= 1'b0;
         op_div   <= 1'b0;
         cap_data <= '0;
         cap_exc  <= 1'b0;
      end else begin
         if (accept) begin
            op_a    <= pipe.req_opA;
            op_b    <= pipe.req_opB;
            dest    <= pipe.req_dest;
            op_mult <= pipe.req_is_mult;
            op_div  <= !pipe.req_is_mult;
         end
         // a unit ready beats a simultaneous timeout; timeout forces data 0 with exception
         if (finish) begin
            cap_data <= sel_rdy ? (op_mult ? mult_result : div_result) : '0;
            cap_exc  <= sel_rdy ? (op_mult ? mult_exception : div_exception) : 1'b1;
         end
      end
   mdu_timeout_counter #(.TC(TIMEOUT)) u_tmo (
      .clock (clock),
      .resetn(resetn),
      .clr   (state == START),
      .en    (state == BUSY),
      .tc    (tc)
   );
   assign pipe.req_ready    = state == IDLE;
   assign pipe.stall        = state == START || state == BUSY;
   assign ctrl_MULT         = state == START && op_mult;
   assign ctrl_DIV          = state == START && op_div;
   assign mdu_opA           = op_a;
   assign mdu_opB           = op_b;
   assign pipe.wb_valid     = state == DONE && !pipe.flush;
   assign pipe.wb_dest      = state == DONE ? dest : '0;
   assign pipe.wb_data      = state == DONE && !cap_exc ? cap_data : '0;
   assign pipe.wb_exception = state == DONE && cap_exc;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed checks of the mult/div sequencer with stub units
module tb_multdiv_ctrl;
   logic        clock, resetn;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] mdu_opA, mdu_opB;
   logic [31:0] mult_result, div_result;
   logic        mult_exception, mult_rdy, div_exception, div_rdy, div_rdy_s;
   int          n_cmp, n_err, n;
   multdiv_ctrl_if #(.WIDTH(32), .TAG_W(5)) pipe ();
   multdiv_ctrl dut (
      .clock         (clock),
      .resetn        (resetn),
      .pipe          (pipe),
      .ctrl_MULT     (ctrl_MULT),
      .ctrl_DIV      (ctrl_DIV),
      .mdu_opA       (mdu_opA),
      .mdu_opB       (mdu_opB),
      .mult_result   (mult_result),
      .mult_exception(mult_exception),
      .mult_rdy      (mult_rdy),
      .div_result    (div_result),
      .div_exception (div_exception),
      .div_rdy       (div_rdy)
   );
   // divider stub flags divide-by-zero combinationally from the held divisor
   assign mult_result   = mdu_opA * mdu_opB;
   assign div_exception = mdu_opB == 32'd0;
   assign div_rdy       = div_rdy_s || div_exception;
   assign div_result    = div_exception ? 32'd0 : 32'($signed(mdu_opA) / $signed(mdu_opB));
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(negedge clock);
   endtask
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
      pipe.req_valid   = 1'b1;
      pipe.req_is_mult = m;
      pipe.req_is_div  = d;
      pipe.req_opA     = a;
      pipe.req_opB     = b;
      pipe.req_dest    = t;
   endtask
   task automatic drop();
      pipe.req_valid   = 1'b0;
      pipe.req_is_mult = 1'b0;
      pipe.req_is_div  = 1'b0;
   endtask
   initial begin
      n_cmp = 0; n_err = 0;
      clock = 0; resetn = 1;
      pipe.req_valid = 0; pipe.req_is_mult = 0; pipe.req_is_div = 0;
      pipe.req_opA = 0; pipe.req_opB = 0; pipe.req_dest = 0; pipe.flush = 0;
      mult_exception = 0; mult_rdy = 0; div_rdy_s = 0;
      #1 resetn = 0;
      step();
      chk("rst_ready", pipe.req_ready, 1);
      chk("rst_stall", pipe.stall, 0);
      chk("rst_mult", ctrl_MULT, 0);
      chk("rst_div", ctrl_DIV, 0);
      chk("rst_wbv", pipe.wb_valid, 0);
      chk("rst_opa", mdu_opA, 0);
      resetn = 1;
      pipe.req_valid = 1;
      step();
      chk("noflag_ready", pipe.req_ready, 1);
      chk("noflag_stall", pipe.stall, 0);
      issue(1, 0, 6, 7, 5);
      pipe.flush = 1;
      step();
      chk("flush_idle_ready", pipe.req_ready, 1);
      chk("flush_idle_opa", mdu_opA, 0);
      pipe.flush = 0;
      step();
      drop();
      chk("m_start_mult", ctrl_MULT, 1);
      chk("m_start_div", ctrl_DIV, 0);
      chk("m_start_stall", pipe.stall, 1);
      chk("m_start_ready", pipe.req_ready, 0);
      chk("m_opa", mdu_opA, 6);
      chk("m_opb", mdu_opB, 7);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("m_busy_mult", ctrl_MULT, 0);
         chk("m_busy_stall", pipe.stall, 1);
         chk("m_busy_wbv", pipe.wb_valid, 0);
      end
      mult_rdy = 1;
      step();
      mult_rdy = 0;
      chk("m_wbv", pipe.wb_valid, 1);
      chk("m_data", pipe.wb_data, 42);
      chk("m_dest", pipe.wb_dest, 5);
      chk("m_exc", pipe.wb_exception, 0);
      chk("m_done_stall", pipe.stall, 0);
      step();
      chk("m_after_wbv", pipe.wb_valid, 0);
      chk("m_after_ready", pipe.req_ready, 1);
      issue(0, 1, 32'hFFFF_FFEC, 3, 9);
      step();
      drop();
      chk("d_start_div", ctrl_DIV, 1);
      chk("d_start_mult", ctrl_MULT, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("d_busy_div", ctrl_DIV, 0);
         chk("d_busy_opa", mdu_opA, 32'hFFFF_FFEC);
      end
      div_rdy_s = 1;
      step();
      div_rdy_s = 0;
      chk("d_wbv", pipe.wb_valid, 1);
      chk("d_data", pipe.wb_data, 32'hFFFF_FFFA);
      chk("d_exc", pipe.wb_exception, 0);
      chk("d_dest", pipe.wb_dest, 9);
      chk("d_done_opa", mdu_opA, 32'hFFFF_FFEC);
      chk("d_done_opb", mdu_opB, 3);
      step();
      issue(0, 1, 17, 0, 3);
      step();
      drop();
      chk("z_start_div", ctrl_DIV, 1);
      step();
      chk("z_busy_stall", pipe.stall, 1);
      chk("z_busy_wbv", pipe.wb_valid, 0);
      step();
      chk("z_wbv", pipe.wb_valid, 1);
      chk("z_exc", pipe.wb_exception, 1);
      chk("z_data", pipe.wb_data, 0);
      chk("z_dest", pipe.wb_dest, 3);
      step();
      issue(1, 0, 3, 4, 1);
      step();
      drop();
      step();
      step();
      step();
      pipe.flush = 1;
      mult_rdy = 1;
      #1;
      chk("f_busy_stall", pipe.stall, 1);
      chk("f_busy_wbv", pipe.wb_valid, 0);
      step();
      pipe.flush = 0;
      mult_rdy = 0;
      chk("f_idle_ready", pipe.req_ready, 1);
      chk("f_idle_stall", pipe.stall, 0);
      chk("f_idle_wbv", pipe.wb_valid, 0);
      issue(1, 0, 8, 9, 2);
      step();
      drop();
      chk("f2_start_mult", ctrl_MULT, 1);
      step();
      mult_rdy = 1;
      step();
      mult_rdy = 0;
      chk("f2_wbv", pipe.wb_valid, 1);
      chk("f2_data", pipe.wb_data, 72);
      chk("f2_dest", pipe.wb_dest, 2);
      pipe.flush = 1;
      #1;
      chk("f_done_masked", pipe.wb_valid, 0);
      step();
      pipe.flush = 0;
      chk("f2_after_ready", pipe.req_ready, 1);
      issue(1, 1, 5, 6, 7);
      step();
      drop();
      chk("t_start_mult", ctrl_MULT, 1);
      chk("t_start_div", ctrl_DIV, 0);
      div_rdy_s = 1;
      n = 0;
      step();
      while (pipe.stall && n < 100) begin
         n++;
         step();
      end
      div_rdy_s = 0;
      chk("t_busy_cycles", n, 40);
      chk("t_wbv", pipe.wb_valid, 1);
      chk("t_exc", pipe.wb_exception, 1);
      chk("t_data", pipe.wb_data, 0);
      chk("t_dest", pipe.wb_dest, 7);
      step();
      issue(1, 0, 2, 3, 4);
      step();
      drop();
      step();
      step();
      resetn = 0;
      #1;
      chk("r_stall", pipe.stall, 0);
      chk("r_ready", pipe.req_ready, 1);
      chk("r_mult", ctrl_MULT, 0);
      chk("r_wbv", pipe.wb_valid, 0);
      chk("r_opa", mdu_opA, 0);
      chk("r_opb", mdu_opB, 0);
      step();
      resetn = 1;
      step();
      chk("r_after_wbv", pipe.wb_valid, 0);
      chk("r_after_ready", pipe.req_ready, 1);
      issue(1, 0, 10, 11, 6);
      step();
      drop();
      step();
      mult_rdy = 1;
      step();
      mult_rdy = 0;
      chk("b_wbv", pipe.wb_valid, 1);
      chk("b_data", pipe.wb_data, 110);
      issue(0, 1, 100, 7, 8);
      #1;
      chk("b_done_ready", pipe.req_ready, 0);
      step();
      chk("b_idle_ready", pipe.req_ready, 1);
      chk("b_idle_stall", pipe.stall, 0);
      chk("b_idle_opa", mdu_opA, 10);
      step();
      drop();
      chk("b2_start_div", ctrl_DIV, 1);
      chk("b2_opa", mdu_opA, 100);
      step();
      div_rdy_s = 1;
      step();
      div_rdy_s = 0;
      chk("b2_wbv", pipe.wb_valid, 1);
      chk("b2_data", pipe.wb_data, 14);
      chk("b2_dest", pipe.wb_dest, 8);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
